// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the buffered 1:4 demultiplexer
//
// Contents:
//   N_OUT      number of output streams
//   SEL_W      width of the destination select
//   FIFO_DEPTH entries per output buffer
//   occ_t      per-buffer occupancy count (0..FIFO_DEPTH)
package demux_pkg;

    localparam int N_OUT      = 4;
    localparam int SEL_W      = 2;
    localparam int FIFO_DEPTH = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_2_entry.sv
// rtl/fifo_2_entry.sv - two-entry FIFO buffering one demultiplexer output
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; clears occupancy, pointers and storage
//   push       write push_data this cycle (ignored when full)
//   push_data  payload to write
//   pop        consumer takes head this cycle (ignored when empty)
//   head_data  oldest stored beat
//   empty      occupancy is zero
//   full       occupancy equals DEPTH
module fifo_2_entry
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem [DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    occ_t         occ;

    logic do_push;
    logic do_pop;

    // Guards make the buffer safe on its own: a push into a full buffer or a
    // pop from an empty one is a no-op rather than corrupting the count.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({do_push, do_pop})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Full/empty come from the occupancy count; the pointers are equal both
    // when empty and when full, so they cannot distinguish the two.
    assign empty     = (occ == occ_t'(0));
    assign full      = (occ == occ_t'(DEPTH));
    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/demux_1_4_buffered.sv
// rtl/demux_1_4_buffered.sv - 1:4 stream demultiplexer with a 2-entry FIFO per output
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; flushes all buffers
//   in_valid   input beat present
//   in_sel     destination output index 0..3
//   in_data    input payload
//   in_ready   selected output buffer has room
//   out_valid  bit i: output i holds a beat
//   out_data   slice [i*W +: W]: head beat of output i
//   out_ready  bit i: consumer i takes the beat
module demux_1_4_buffered
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [W-1:0]       in_data,
    output logic               in_ready,
    output logic [N_OUT-1:0]   out_valid,
    output logic [N_OUT*W-1:0] out_data,
    input  logic [N_OUT-1:0]   out_ready
);

    logic [N_OUT-1:0] full_vec;
    logic [N_OUT-1:0] empty_vec;
    logic [N_OUT-1:0] push_vec;

    // Ready depends only on registered occupancy of the selected buffer, so a
    // pop in the same cycle never opens a slot for the incoming beat.
    assign in_ready = !full_vec[in_sel];

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        assign push_vec[i]  = in_valid && in_ready && (in_sel == SEL_W'(i));
        assign out_valid[i] = !empty_vec[i];

        fifo_2_entry #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_vec[i]),
            .push_data (in_data),
            .pop       (out_ready[i]),
            .head_data (out_data[i*W +: W]),
            .empty     (empty_vec[i]),
            .full      (full_vec[i])
        );
    end

endmodule
